// File: rtl/jk_mod_counter_pkg.sv
// Shared constants for the JK-cell mod-N counter: JK excitation codes and
// count-direction encoding.
package jk_mod_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_e;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/jk_mod_counter_cell.sv
// Single JK flip-flop storage cell with asynchronous active-low reset.
module jk_cell
    import jk_mod_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_HOLD:  Q <= Q;
                JK_RESET: Q <= 1'b0;
                JK_SET:   Q <= 1'b1;
                default:  Q <= ~Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter built from JK cells; this level computes the per-bit
// J/K excitation, the combinational terminal count and the registered wrap pulse.
module jk_mod_counter
    import jk_mod_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_upd;
    logic             w_wrap_nxt;
    logic             w_q_oor;
    logic             r_wrap;

    // Widened compares stay meaningful even when MODULUS == 2**WIDTH.
    assign w_q_oor = ({1'b0, w_q} >= MOD_W);

    always_comb begin
        w_upd      = 1'b0;
        w_nxt      = w_q;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_upd = 1'b1;
            w_nxt = ({1'b0, d} >= MOD_W) ? MAX_Q : d;
        end else if (en) begin
            w_upd = 1'b1;
            if (up == DIR_UP) begin
                if (w_q_oor || (w_q == MAX_Q)) begin
                    w_nxt      = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_nxt = WIDTH'({1'b0, w_q} + (WIDTH + 1)'(1));
                end
            end else begin
                if (w_q_oor || (w_q == '0)) begin
                    w_nxt      = MAX_Q;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_nxt = WIDTH'({1'b0, w_q} - (WIDTH + 1)'(1));
                end
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        assign {w_j[gi], w_k[gi]} = !w_upd     ? JK_HOLD
                                  : w_nxt[gi]  ? JK_SET
                                  :              JK_RESET;

        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .J     (w_j[gi]),
            .K     (w_k[gi]),
            .Q     (w_q[gi])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_nxt;
        end
    end

    assign q    = w_q;
    assign wrap = r_wrap;
    assign tc   = en & ~load & ((up & (w_q == MAX_Q)) | (~up & (w_q == '0)));

endmodule
